// File: rtl/wrr_pkg.sv
// Shared constants, FSM state type and one-hot encoder for the weighted
// round-robin pop arbiter.
package wrr_pkg;

  localparam int NQ  = 4;
  localparam int IDW = 2;
  localparam int WW  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // OR-reduce so a malformed (multi-hot) vector still yields a defined id.
  function automatic logic [IDW-1:0] onehot_to_id(input logic [NQ-1:0] oh);
    logic [IDW-1:0] id;
    id = {IDW{1'b0}};
    for (int i = 0; i < NQ; i++) begin
      id = id | ({IDW{oh[i]}} & IDW'(i));
    end
    return id;
  endfunction

endpackage

// File: rtl/wrr_pop_arbiter_rr_pick.sv
// Rotating priority encoder: grants the first set request at or after ptr,
// wrapping modulo NQ.
module rr_pick #(
  parameter int NQ  = 4,
  parameter int IDW = 2
) (
  input  logic [NQ-1:0]  req,
  input  logic [IDW-1:0] ptr,
  output logic [NQ-1:0]  gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  logic [IDW-1:0] idx_s;

  // Walk ptr, ptr+1, ... and keep the first hit; idx wraps naturally in IDW bits.
  always_comb begin
    gnt    = {NQ{1'b0}};
    gnt_id = {IDW{1'b0}};
    any    = 1'b0;
    idx_s  = {IDW{1'b0}};
    for (int i = 0; i < NQ; i++) begin
      idx_s = ptr + IDW'(i);
      if (!any && req[idx_s]) begin
        any         = 1'b1;
        gnt[idx_s]  = 1'b1;
        gnt_id      = idx_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/wrr_pop_arbiter.sv
// Weighted round-robin FIFO pop scheduler with runtime weights.
// Build option: STRICT_Q0_EN gives queue 0 strict priority over the rotation.
module wrr_pop_arbiter #(
  parameter int NQ             = wrr_pkg::NQ,
  parameter int IDW            = wrr_pkg::IDW,
  parameter int WW             = wrr_pkg::WW,
  parameter int WEIGHT_DEFAULT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NQ-1:0]  empty,
  input  logic [NQ-1:0]  almost_empty,
  input  logic           out_ready,
  input  logic           cfg_we,
  input  logic [IDW-1:0] cfg_addr,
  input  logic [WW-1:0]  cfg_weight,
  output logic [NQ-1:0]  pop,
  output logic [IDW-1:0] pop_id,
  output logic           valid,
  output logic           busy
);

  import wrr_pkg::state_t;
  import wrr_pkg::IDLE;
  import wrr_pkg::BURST;
  import wrr_pkg::onehot_to_id;

`ifdef STRICT_Q0_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  localparam logic [IDW-1:0] ONE_ID = IDW'(1);
  localparam logic [WW-1:0]  ONE_W  = WW'(1);

  state_t         state_r, nstate_s;
  logic [IDW-1:0] ptr_r, nptr_s, cur_r, ncur_s, pop_id_r;
  logic [WW-1:0]  credit_r, ncredit_s;
  logic [WW-1:0]  weight_r [NQ];
  logic [NQ-1:0]  last_pop_r, last_ae_r, wnz_s, elig_s, pop_s, pick_gnt_s;
  logic [IDW-1:0] pick_id_s, sel_id_s;
  logic           pick_any_s, sel_go_s, valid_r, busy_r;

  // Queue 0 service leaves the rotation pointer alone when it has strict priority.
  function automatic logic [IDW-1:0] adv_ptr(input logic [IDW-1:0] id,
                                             input logic [IDW-1:0] ptr);
    return (STRICT && id == {IDW{1'b0}}) ? ptr : id + ONE_ID;
  endfunction

  // Eligibility: non-empty, enabled, and not the one-word FIFO we just drained.
  always_comb begin
    wnz_s = {NQ{1'b0}};
    for (int q = 0; q < NQ; q++) begin
      wnz_s[q] = (weight_r[q] != {WW{1'b0}});
    end
    elig_s = ~empty & wnz_s & ~(last_pop_r & last_ae_r);
  end

  rr_pick #(.NQ(NQ), .IDW(IDW)) u_pick (
    .req    (elig_s),
    .ptr    (ptr_r),
    .gnt    (pick_gnt_s),
    .gnt_id (pick_id_s),
    .any    (pick_any_s)
  );

  // Start-of-burst selection, with optional queue 0 override.
  always_comb begin
    if (STRICT && elig_s[0]) begin
      sel_id_s = {IDW{1'b0}};
      sel_go_s = out_ready;
    end else begin
      sel_id_s = pick_id_s;
      sel_go_s = out_ready & pick_any_s;
    end
  end

  // Pop decision and next-state computation.
  always_comb begin
    pop_s     = {NQ{1'b0}};
    nstate_s  = state_r;
    nptr_s    = ptr_r;
    ncur_s    = cur_r;
    ncredit_s = credit_r;
    case (state_r)
      IDLE: begin
        if (sel_go_s) begin
          pop_s[sel_id_s] = 1'b1;
          ncur_s          = sel_id_s;
          ncredit_s       = weight_r[sel_id_s] - ONE_W;
          if (weight_r[sel_id_s] == ONE_W) begin
            nptr_s = adv_ptr(sel_id_s, ptr_r);
          end else begin
            nstate_s = BURST;
          end
        end else begin
          nstate_s = IDLE;
        end
      end
      BURST: begin
        if (!out_ready) begin
          nstate_s = BURST;
        end else if (STRICT && cur_r != {IDW{1'b0}} && elig_s[0]) begin
          pop_s[0]  = 1'b1;
          ncredit_s = {WW{1'b0}};
          nptr_s    = cur_r + ONE_ID;
          nstate_s  = IDLE;
        end else if (elig_s[cur_r]) begin
          pop_s[cur_r] = 1'b1;
          ncredit_s    = (credit_r != {WW{1'b0}}) ? credit_r - ONE_W : {WW{1'b0}};
          if (credit_r <= ONE_W) begin
            nptr_s   = adv_ptr(cur_r, ptr_r);
            nstate_s = IDLE;
          end else begin
            nstate_s = BURST;
          end
        end else begin
          ncredit_s = {WW{1'b0}};
          nptr_s    = adv_ptr(cur_r, ptr_r);
          nstate_s  = IDLE;
        end
      end
      default: begin
        nstate_s  = IDLE;
        ncredit_s = {WW{1'b0}};
      end
    endcase
    if (reset) begin
      pop_s = {NQ{1'b0}};
    end else begin
      pop_s = pop_s;
    end
  end

  // State, weight table and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= {IDW{1'b0}};
      cur_r      <= {IDW{1'b0}};
      credit_r   <= {WW{1'b0}};
      last_pop_r <= {NQ{1'b0}};
      last_ae_r  <= {NQ{1'b0}};
      valid_r    <= 1'b0;
      pop_id_r   <= {IDW{1'b0}};
      busy_r     <= 1'b0;
      for (int q = 0; q < NQ; q++) begin
        weight_r[q] <= WW'(WEIGHT_DEFAULT);
      end
    end else begin
      state_r    <= nstate_s;
      ptr_r      <= nptr_s;
      cur_r      <= ncur_s;
      credit_r   <= ncredit_s;
      last_pop_r <= pop_s;
      last_ae_r  <= almost_empty;
      valid_r    <= |pop_s;
      busy_r     <= (nstate_s == BURST);
      if (|pop_s) begin
        pop_id_r <= onehot_to_id(pop_s);
      end
      if (cfg_we) begin
        weight_r[cfg_addr] <= cfg_weight;
      end
    end
  end

  assign pop    = pop_s;
  assign pop_id = pop_id_r;
  assign valid  = valid_r;
  assign busy   = busy_r;

endmodule
